mult_test_sequencer: RTL and testbench

//  Self-checking stimulus controller for the 16x16 multiplier test datapath.

---
 rtl/mult_test_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mult_test_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_test_sequencer.sv
// Sweep controller that walks every {a,b} operand pair through a multiplier under test
// and checks each product against a reference. Optional watchdog: define MTS_TIMEOUT_EN.
module mult_test_sequencer #(
  parameter int WIDTH          = 16,
  parameter int ERR_CNT_W      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   op_valid_o,
  input  logic                   op_ready_i,
  output logic [WIDTH-1:0]       op_a_o,
  output logic [WIDTH-1:0]       op_b_o,
  input  logic                   prod_valid_i,
  input  logic [2*WIDTH-1:0]     prod_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ERR_CNT_W-1:0]   err_count_o,
  output logic                   err_valid_o,
  output logic [WIDTH-1:0]       err_a_o,
  output logic [WIDTH-1:0]       err_b_o,
  output logic                   timeout_o
);

  localparam int IDX_W = 2 * WIDTH;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef MTS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [IDX_W-1:0]     expected_q, expected_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 err_valid_q, err_valid_d;
  logic [WIDTH-1:0]     err_a_q, err_a_d;
  logic [WIDTH-1:0]     err_b_q, err_b_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 op_valid_q, op_valid_d;
  logic                 busy_q, busy_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 err_hit_s;

  function automatic logic [IDX_W-1:0] ref_product(input logic [IDX_W-1:0] idx);
    return IDX_W'(idx[IDX_W-1:WIDTH]) * IDX_W'(idx[WIDTH-1:0]);
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      expected_q  <= '0;
      err_count_q <= '0;
      err_valid_q <= 1'b0;
      err_a_q     <= '0;
      err_b_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      op_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
      err_valid_q <= err_valid_d;
      err_a_q     <= err_a_d;
      err_b_q     <= err_b_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      op_valid_q  <= op_valid_d;
      busy_q      <= busy_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    expected_d  = expected_q;
    err_count_d = err_count_q;
    err_valid_d = err_valid_q;
    err_a_d     = err_a_q;
    err_b_d     = err_b_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_hit_s   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_ISSUE;
          index_d     = '0;
          done_d      = 1'b0;
          err_count_d = '0;
          err_valid_d = 1'b0;
          err_a_d     = '0;
          err_b_d     = '0;
          timeout_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        if (op_ready_i) begin
          expected_d = ref_product(index_q);
          tmo_cnt_d  = '0;
          state_d    = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (prod_valid_i) begin
          err_hit_s = (prod_i != expected_q);
          // The last pair finishes the sweep rather than wrapping the index.
          if (index_q == '1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + IDX_W'(1);
            state_d = S_ISSUE;
          end
        end else if (TMO_EN && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
          err_hit_s = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
          done_d    = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (err_hit_s) begin
      if (err_count_q != '1) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end else begin
        err_count_d = err_count_q;
      end
      if (!err_valid_q) begin
        err_valid_d = 1'b1;
        err_a_d     = index_q[IDX_W-1:WIDTH];
        err_b_d     = index_q[WIDTH-1:0];
      end else begin
        err_valid_d = err_valid_q;
      end
    end else begin
      err_valid_d = err_valid_d;
    end

    // Abort overrides start and any in-flight transition; error status is kept.
    if (abort_i) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      done_d = done_d;
    end

    pass_d     = done_d && (err_count_d == '0) && !timeout_d;
    op_valid_d = (state_d == S_ISSUE);
    busy_d     = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  assign op_valid_o  = op_valid_q;
  assign op_a_o      = index_q[IDX_W-1:WIDTH];
  assign op_b_o      = index_q[WIDTH-1:0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_count_q;
  assign err_valid_o = err_valid_q;
  assign err_a_o     = err_a_q;
  assign err_b_o     = err_b_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mult_test_sequencer.sv
// Directed bench for mult_test_sequencer at WIDTH=2 (16 pairs) with a behavioural multiplier
// and an operand-pair scoreboard. Timeout scenario needs MTS_TIMEOUT_EN.
module tb_mult_test_sequencer;

  logic        clock_i;
  logic        reset_i;
  logic        start_i;
  logic        abort_i;
  logic        op_valid_o;
  logic        op_ready_i;
  logic [1:0]  op_a_o;
  logic [1:0]  op_b_o;
  logic        prod_valid_i;
  logic [3:0]  prod_i;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [15:0] err_count_o;
  logic        err_valid_o;
  logic [1:0]  err_a_o;
  logic [1:0]  err_b_o;
  logic        timeout_o;

  int          err_cnt = 0;
  int          chk_cnt = 0;

  logic [3:0]  exp_q[$];
  logic [3:0]  exp_pair;
  logic        hs_now;
  logic [1:0]  ha, hb;
  logic        prev_legit;
  logic        answer_en, bad_en, spur_en, stall_en;
  int          stall_cnt;

  mult_test_sequencer #(
    .WIDTH          (2),
    .ERR_CNT_W      (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .op_valid_o   (op_valid_o),
    .op_ready_i   (op_ready_i),
    .op_a_o       (op_a_o),
    .op_b_o       (op_b_o),
    .prod_valid_i (prod_valid_i),
    .prod_i       (prod_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .err_count_o  (err_count_o),
    .err_valid_o  (err_valid_o),
    .err_a_o      (err_a_o),
    .err_b_o      (err_b_o),
    .timeout_o    (timeout_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Multiplier model plus scoreboard: pairs are popped and compared at each handshake.
  initial begin
    op_ready_i   = 1'b1;
    prod_valid_i = 1'b0;
    prod_i       = 4'h0;
    hs_now       = 1'b0;
    ha           = 2'd0;
    hb           = 2'd0;
    prev_legit   = 1'b0;
    stall_cnt    = 0;
    forever begin
      @(negedge clock_i);
      if (stall_en && stall_cnt == 0 && op_valid_o && op_a_o == 2'd1 && op_b_o == 2'd2) begin
        op_ready_i = 1'b0;
        stall_cnt  = 1;
      end else if (stall_cnt >= 1 && stall_cnt <= 5) begin
        chk("stall_hold", {29'd0, op_valid_o, op_a_o, op_b_o}, {29'd0, 1'b1, 2'd1, 2'd2});
        op_ready_i = (stall_cnt == 5);
        stall_cnt++;
      end else begin
        op_ready_i = 1'b1;
      end
      hs_now = op_valid_o && op_ready_i;
      if (hs_now) begin
        ha = op_a_o;
        hb = op_b_o;
        chk("pair_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          exp_pair = exp_q.pop_front();
          chk("pair_order", {28'd0, op_a_o, op_b_o}, {28'd0, exp_pair});
        end
      end
      @(posedge clock_i);
      #1;
      if (hs_now && answer_en) begin
        prod_valid_i = 1'b1;
        prod_i       = (4'(ha) * 4'(hb)) ^ ((bad_en && ha == 2'd2 && hb == 2'd3) ? 4'h1 : 4'h0);
        prev_legit   = 1'b1;
      end else if (spur_en && prev_legit) begin
        prod_valid_i = 1'b1;
        prod_i       = 4'hF;
        prev_legit   = 1'b0;
      end else begin
        prod_valid_i = 1'b0;
        prev_legit   = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clock_i);
    #2;
  endtask

  task automatic start_sweep();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    chk("start_done_clr", {31'd0, done_o}, 32'd0);
    chk("start_err_clr", {16'd0, err_count_o}, 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (done_o) break;
      step();
    end
    chk("done_reached", {31'd0, done_o}, 32'd1);
  endtask

  task automatic check_clean_pass(input string tag);
    chk({tag, "_pass"}, {31'd0, pass_o}, 32'd1);
    chk({tag, "_errcnt"}, {16'd0, err_count_o}, 32'd0);
    chk({tag, "_errvalid"}, {31'd0, err_valid_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_all_pairs"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic found;
    int   cyc;
    reset_i   = 1'b1;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    answer_en = 1'b1;
    bad_en    = 1'b0;
    spur_en   = 1'b0;
    stall_en  = 1'b0;
    repeat (3) step();
    chk("rst_outputs", {19'd0, op_valid_o, op_a_o, op_b_o, busy_o, done_o, pass_o, err_valid_o,
                        err_a_o, err_b_o, timeout_o}, 32'd0);
    chk("rst_errcnt", {16'd0, err_count_o}, 32'd0);
    reset_i = 1'b0;
    step();

    // Clean sweep, ready always high.
    start_sweep();
    wait_done();
    check_clean_pass("s1");

    // Single wrong product at (2,3).
    bad_en = 1'b1;
    start_sweep();
    wait_done();
    bad_en = 1'b0;
    chk("s2_pass", {31'd0, pass_o}, 32'd0);
    chk("s2_errcnt", {16'd0, err_count_o}, 32'd1);
    chk("s2_errvalid", {31'd0, err_valid_o}, 32'd1);
    chk("s2_err_pair", {28'd0, err_a_o, err_b_o}, {28'd0, 2'd2, 2'd3});

    // Back-pressure on pair (1,2).
    stall_en  = 1'b1;
    stall_cnt = 0;
    start_sweep();
    wait_done();
    stall_en = 1'b0;
    chk("s3_stall_cycles", stall_cnt, 32'd6);
    check_clean_pass("s3");

    // Abort during WAIT of pair (2,0).
    start_sweep();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (hs_now && ha == 2'd2 && hb == 2'd0) found = 1'b1;
    end
    chk("s4_pair_found", {31'd0, found}, 32'd1);
    step();
    chk("s4_wait_opvalid", {31'd0, op_valid_o}, 32'd0);
    chk("s4_wait_busy", {31'd0, busy_o}, 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    exp_q.delete();
    chk("s4_abort_idle", {29'd0, busy_o, done_o, op_valid_o}, 32'd0);
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("s4_abort_beats_start", {31'd0, busy_o}, 32'd0);
    start_sweep();
    chk("s4_restart_pair", {28'd0, op_a_o, op_b_o}, 32'd0);
    wait_done();
    check_clean_pass("s4");

    // Extra start while busy, spurious prod_valid outside WAIT.
    spur_en = 1'b1;
    start_sweep();
    repeat (5) step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done();
    spur_en = 1'b0;
    step();
    check_clean_pass("s6");

    // Reset in mid-sweep.
    start_sweep();
    repeat (5) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    exp_q.delete();
    chk("midrst_state", {25'd0, op_valid_o, op_a_o, op_b_o, busy_o, done_o, pass_o}, 32'd0);
    step();
    chk("midrst_stays_idle", {30'd0, busy_o, done_o}, 32'd0);

`ifdef MTS_TIMEOUT_EN
    // Multiplier never answers (0,0); watchdog fires after 8 WAIT cycles.
    answer_en = 1'b0;
    start_sweep();
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      cyc++;
      if (done_o) break;
    end
    answer_en = 1'b1;
    exp_q.delete();
    chk("s5_done_cycle", cyc, 32'd9);
    chk("s5_timeout", {31'd0, timeout_o}, 32'd1);
    chk("s5_pass", {31'd0, pass_o}, 32'd0);
    chk("s5_errcnt", {16'd0, err_count_o}, 32'd1);
    chk("s5_err_pair", {27'd0, err_valid_o, err_a_o, err_b_o}, {27'd0, 1'b1, 4'd0});
`else
    cyc = 0;
    chk("timeout_tied", {31'd0, timeout_o}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
